// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
//   DIV_W     : default divisor/quotient/remainder width (dividend is 2*DIV_W)
//   state_t   : divider control states
//   cnt_width : iteration counter width for a given operand width
package div_pkg;

    localparam int unsigned DIV_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter must be able to hold 0..w
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    localparam int unsigned DIV_CNT_W = cnt_width(DIV_W);

endpackage

// File: rtl/div_step.sv
// One shift-and-trial-subtract step of a restoring divider (combinational).
//   r      : partial remainder, W+1 bits
//   q      : partial quotient / remaining dividend bits, W bits
//   d      : divisor, W bits
//   r_next : partial remainder after this step
//   q_next : quotient after this step (new bit enters at LSB)
module div_step #(
    parameter int unsigned W = 16
) (
    input  logic [W:0]   r,
    input  logic [W-1:0] q,
    input  logic [W-1:0] d,
    output logic [W:0]   r_next,
    output logic [W-1:0] q_next
);

    // One extra headroom bit so the shifted remainder never wraps
    logic [W+1:0] r_shift;
    logic [W+1:0] trial;
    logic         fits;

    always_comb begin
        r_shift = {r, q[W-1]};
        trial   = r_shift - (W+2)'(d);
        fits    = (r_shift >= (W+2)'(d));
        r_next  = (W+1)'(fits ? trial : r_shift);
        q_next  = {q[W-2:0], fits};
    end

endmodule

// File: rtl/seq_divider_32by16.sv
// Sequential restoring divider: 2W-bit dividend / W-bit divisor -> W-bit
// quotient and remainder, one quotient bit per clock, valid/ready on both sides.
//   clk, rst_n            : clock, synchronous active-low reset
//   in_valid / in_ready   : operand handshake (in_ready while idle)
//   dividend, divisor     : unsigned operands, captured at accept
//   out_valid / out_ready : result handshake (out_valid while done)
//   quotient, remainder   : results
//   div_by_zero, overflow : error flags; quotient is all ones when either is set
module seq_divider_32by16
    import div_pkg::*;
#(
    parameter int unsigned W = DIV_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] dividend,
    input  logic [W-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W-1:0]   quotient,
    output logic [W-1:0]   remainder,
    output logic           div_by_zero,
    output logic           overflow
);

    localparam int unsigned CW = cnt_width(W);

    state_t        state;
    state_t        state_next;
    logic [W:0]    r;
    logic [W-1:0]  q;
    logic [W-1:0]  d;
    logic [CW-1:0] cnt;

    logic [W:0]    r_step;
    logic [W-1:0]  q_step;

    logic          accept;
    logic          zero_div;
    logic          too_big;
    logic          last_iter;

    div_step #(.W(W)) u_step (
        .r      (r),
        .q      (q),
        .d      (d),
        .r_next (r_step),
        .q_next (q_step)
    );

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    // Handshake and error decode for the accept edge
    always_comb begin
        accept    = in_valid && (state == IDLE);
        zero_div  = (divisor == '0);
        too_big   = (dividend[2*W-1:W] >= divisor);
        last_iter = (cnt == CW'(W - 1));
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (zero_div || too_big) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r           <= '0;
            q           <= '0;
            d           <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        d   <= divisor;
                        r   <= {1'b0, dividend[2*W-1:W]};
                        q   <= dividend[W-1:0];
                        cnt <= '0;
                        // Error results are final immediately; normal ones
                        // are written when the last iteration retires
                        div_by_zero <= zero_div;
                        overflow    <= !zero_div && too_big;
                        if (zero_div || too_big) begin
                            quotient  <= '1;
                            remainder <= dividend[W-1:0];
                        end
                    end
                end
                CALC: begin
                    r   <= r_step;
                    q   <= q_step;
                    cnt <= cnt + CW'(1);
                    if (last_iter) begin
                        quotient  <= q_step;
                        remainder <= r_step[W-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/seq_divider_32by16.md
# seq_divider_32by16

Sequential restoring divider that undoes the 16x16 array multiplier. It divides a 2W-bit dividend by a W-bit divisor and returns a W-bit quotient and a W-bit remainder, retiring one quotient bit per clock. It sits on the datapath wherever a product must be scaled back down or inverted. Operands arrive and results leave over valid/ready handshakes.

## Interface
- `W`, default 16: divisor, quotient and remainder width. The dividend is 2W bits.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: reset, synchronous and active-low; one clock, synchronous active-low reset.
- `in_valid` input 1: dividend and divisor are valid.
- `in_ready` output 1: the block accepts an operand pair. Equals `(state==IDLE)`.
- `dividend` input 2W: unsigned dividend.
- `divisor` input W: unsigned divisor.
- `out_valid` output 1: results are valid. Equals `(state==DONE)`.
- `out_ready` input 1: the consumer takes the results.
- `quotient` output W: unsigned quotient.
- `remainder` output W: unsigned remainder.
- `div_by_zero` output 1: the divisor was 0.
- `overflow` output 1: the true quotient does not fit in W bits.

## Operation
- **FSM states:** IDLE, CALC, DONE.
- **Accept:** `in_valid && in_ready` at an edge.
  - Latch the divisor into D.
  - Load R (W+1 bits) with `dividend[2W-1:W]`.
  - Load Q (W bits) with `dividend[W-1:0]`.
  - Clear the iteration counter.
- **Error checks at accept, priority order:**
  - If `divisor==0`: `div_by_zero`=1, `overflow`=0. Go directly to DONE.
  - Else if `dividend[2W-1:W] >= divisor`: `overflow`=1. Go directly to DONE.
  - In both error cases, `quotient` = all ones and `remainder` = `dividend[W-1:0]`.
  - Otherwise go to CALC with both flags cleared.
- **CALC iteration (one per edge):**
  - Shift `{R,Q}` left by 1.
  - Compute `T = R_shifted - {1'b0,D}`.
  - If T is non-negative: R = T and Q[0] = 1. Otherwise R is kept and Q[0] = 0.
  - The counter increments each edge. After W iterations, go to DONE.
- **Result:** `quotient`=Q, `remainder`=R[W-1:0]. R never exceeds D-1, so bit W is always 0 at DONE.
- **Handoff:** DONE goes to IDLE at the edge where `out_ready`=1. Outputs hold steady while `out_valid && !out_ready`.
- **No overlap:** there is no bypass from DONE to accept. `in_ready` rises only in the cycle after the handoff.
- **Reset:** `rst_n`=0 at an edge puts the FSM in IDLE. Q, R, D, the counter, `quotient`, `remainder`, and both flags clear to 0, so `out_valid`=0 and `in_ready`=1 after the reset edge. An operation in flight is discarded without producing output.
- **Operand changes:** changes on `dividend` or `divisor` outside the accept edge are ignored.

## Timing
- **Normal latency:** accept at edge t puts the FSM in CALC. Iterations run on edges t+1 … t+W, and DONE is entered at edge t+W. `out_valid` is high from the cycle after edge t+W, which is W cycles after accept.
- **Error latency:** `out_valid` is high in the cycle after the accept edge (1 cycle).
- **Throughput:** at best one operation per W+2 cycles (accept, W iterations, 1 handoff cycle).
- **Output registers:** all outputs are registered or decode directly from state. There is no combinational path from inputs to outputs.

## Structure
- **Package `div_pkg`:**
  - Default width constant `W=16`.
  - `state_t` enum {IDLE, CALC, DONE}.
  - Counter width `$clog2(W+1)`.
- **Sub-module `div_step`** (combinational, parameter W):
  - Inputs: R, Q, D.
  - Outputs: next R and next Q, i.e. one shift-and-trial-subtract step.
  - The top module instantiates it once and registers its outputs in CALC.

## Test plan
1. **Basic divide:** dividend=1000, divisor=7 → quotient=142, remainder=6. `out_valid` rises exactly 16 cycles after accept; flags 0.
2. **Largest product:** dividend=0xFFFE0001, divisor=0xFFFF → quotient=0xFFFF, remainder=0.
   - Also 1000 random pairs where dividend=a*b, divisor=b≠0 → quotient=a, remainder=0.
3. **Divide by zero:** dividend=0x00001234, divisor=0 → `div_by_zero`=1, `overflow`=0, quotient=0xFFFF, remainder=0x1234. `out_valid` in the cycle after accept.
4. **Overflow:** dividend=0x00010000, divisor=1 → `overflow`=1, quotient=0xFFFF, remainder=0x0000, 1-cycle latency.
   - Boundary: dividend=0x0000FFFF, divisor=1 → quotient=0xFFFF, remainder=0, no overflow.
5. **Backpressure:** hold `out_ready`=0 for 5 cycles in DONE. Outputs stay stable and `in_ready`=0 throughout. After `out_ready`=1, `in_ready`=1 in the next cycle, and a back-to-back operation completes correctly.
6. **Reset mid-operation:** assert `rst_n`=0 for one edge at iteration 8 of 1000/7. Then `out_valid`=0, `in_ready`=1, and all outputs are 0. A following 0x00000064/0x0003 gives quotient=33, remainder=1.
